// File: rtl/load_activity_monitor_if.sv
// Bus bundle for the load activity monitor: enable/clear/load in, window
// results and alarm out. clk and rst stay as plain ports on the block.
interface load_activity_monitor_if #(
  parameter int WIN_LOG2 = 10
);
  logic                  en;
  logic                  clr;
  logic [63:0]           load;
  logic                  win_done;
  logic [WIN_LOG2+6:0]   win_sum;
  logic [3:0]            hit_cnt;
  logic                  alarm;

  modport master (
    output en, clr, load,
    input  win_done, win_sum, hit_cnt, alarm
  );

  modport slave (
    input  en, clr, load,
    output win_done, win_sum, hit_cnt, alarm
  );
endinterface

// File: rtl/load_activity_monitor.sv
// Load activity monitor: counts bit toggles of the 64-bit load vector over
// fixed windows of 2^WIN_LOG2 samples, reports each window sum and raises a
// sticky alarm after HITS consecutive windows above THRESH.
module load_activity_monitor #(
  parameter int WIN_LOG2 = 10,
  parameter int THRESH   = 4096,
  parameter int HITS     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  load_activity_monitor_if.slave  bus
);

  localparam int SUM_W = WIN_LOG2 + 7;
  localparam logic [SUM_W-1:0] THRESH_C = SUM_W'(THRESH);
  localparam logic [3:0]       HITS_C   = 4'(HITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state_r;
  logic [63:0]           load_q_r;
  logic [6:0]            hd_q_r;
  logic                  hd_vld_r;
  logic [SUM_W-1:0]      acc_r;
  logic [WIN_LOG2-1:0]   scnt_r;
  logic [SUM_W-1:0]      win_sum_r;
  logic                  win_done_r;
  logic [3:0]            hit_cnt_r;
  logic                  alarm_r;

  logic [6:0]            hd_s;
  logic [SUM_W-1:0]      new_sum_s;
  logic                  take_s;
  logic                  complete_s;
  logic [3:0]            hit_next_s;

  // Number of set bits in a 64-bit word (0..64).
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  // Toggle distance, running window sum and next consecutive-hit count.
  always_comb begin
    hd_s       = popcount64(bus.load ^ load_q_r);
    new_sum_s  = acc_r + {{(SUM_W-7){1'b0}}, hd_q_r};
    // A pending sample is only consumed while still running; it is dropped
    // in the cycle en falls.
    take_s     = (state_r == RUN) && bus.en && hd_vld_r;
    complete_s = take_s && (&scnt_r);
    if (new_sum_s > THRESH_C) begin
      if (hit_cnt_r >= HITS_C) begin
        hit_next_s = HITS_C;
      end else begin
        hit_next_s = hit_cnt_r + 4'd1;
      end
    end else begin
      hit_next_s = 4'd0;
    end
  end

  // Sequencer, sample pipeline, window accumulator and alarm state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      load_q_r   <= 64'd0;
      hd_q_r     <= 7'd0;
      hd_vld_r   <= 1'b0;
      acc_r      <= '0;
      scnt_r     <= '0;
      win_sum_r  <= '0;
      win_done_r <= 1'b0;
      hit_cnt_r  <= 4'd0;
      alarm_r    <= 1'b0;
    end else begin
      load_q_r   <= bus.load;
      win_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          hd_vld_r <= 1'b0;
          acc_r    <= '0;
          scnt_r   <= '0;
          if (bus.en) state_r <= PRIME;
          else        state_r <= IDLE;
        end
        // One cycle to refresh load_q so the first sample is not taken
        // against a stale reference.
        PRIME: begin
          hd_vld_r <= 1'b0;
          acc_r    <= '0;
          scnt_r   <= '0;
          if (bus.en) state_r <= RUN;
          else        state_r <= IDLE;
        end
        RUN: begin
          if (bus.en) begin
            hd_q_r   <= hd_s;
            hd_vld_r <= 1'b1;
            if (complete_s) begin
              win_sum_r  <= new_sum_s;
              acc_r      <= '0;
              scnt_r     <= '0;
              win_done_r <= 1'b1;
            end else if (take_s) begin
              acc_r  <= new_sum_s;
              scnt_r <= scnt_r + WIN_LOG2'(1);
            end else begin
              acc_r  <= acc_r;
              scnt_r <= scnt_r;
            end
          end else begin
            // Leaving RUN discards the partial window.
            state_r  <= IDLE;
            hd_vld_r <= 1'b0;
            acc_r    <= '0;
            scnt_r   <= '0;
          end
        end
        default: begin
          state_r  <= IDLE;
          hd_vld_r <= 1'b0;
          acc_r    <= '0;
          scnt_r   <= '0;
        end
      endcase
      // clr overrides a coincident window completion for hit/alarm only.
      if (bus.clr) begin
        hit_cnt_r <= 4'd0;
        alarm_r   <= 1'b0;
      end else if (complete_s) begin
        hit_cnt_r <= hit_next_s;
        if (hit_next_s == HITS_C) alarm_r <= 1'b1;
        else                      alarm_r <= alarm_r;
      end else begin
        hit_cnt_r <= hit_cnt_r;
        alarm_r   <= alarm_r;
      end
    end
  end

  assign bus.win_done = win_done_r;
  assign bus.win_sum  = win_sum_r;
  assign bus.hit_cnt  = hit_cnt_r;
  assign bus.alarm    = alarm_r;

endmodule
